// File: rtl/pp_gen_pkg.sv
// Shared types and helpers for the pipelined partial-product generator.
package pp_gen_pkg;

    localparam int unsigned CORR_MAX_W = 128;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pp_state_e;

    // Baugh-Wooley correction: ones at weights 2^width and 2^(2*width-1).
    function automatic logic [CORR_MAX_W-1:0] bw_corr(input int unsigned width);
        return (CORR_MAX_W'(1'b1) << width) | (CORR_MAX_W'(1'b1) << (2 * width - 1));
    endfunction

endpackage

// File: rtl/pp_gen_pipe_matrix.sv
// Combinational partial-product matrix: plain AND array or Baugh-Wooley form.
module pp_matrix
    import pp_gen_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic [WIDTH-1:0]            a_i,
    input  logic [WIDTH-1:0]            b_i,
    input  logic                        signed_i,
    output logic [WIDTH-1:0][WIDTH-1:0] pp_o,
    output logic [2*WIDTH-1:0]          corr_o
);

    localparam logic [CORR_MAX_W-1:0] CORR_FULL = bw_corr(WIDTH);
    localparam logic [2*WIDTH-1:0]    CORR_C    = CORR_FULL[2*WIDTH-1:0];

    logic signed_eff_s;

    assign signed_eff_s = SIGNED_EN ? signed_i : 1'b0;

    // Sign row/column terms are inverted except the sign*sign corner.
    always_comb begin
        pp_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_o[i][j] = (a_i[i] & b_i[j])
                           ^ (signed_eff_s & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
            end
        end
    end

    assign corr_o = signed_eff_s ? CORR_C : '0;

endmodule

// File: rtl/pp_gen_pipe.sv
// Partial-product generator with a two-entry skid buffer towards the reduction tree.
module pp_gen_pipe
    import pp_gen_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    input  logic                        in_signed,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0][WIDTH-1:0] out_pp,
    output logic [2*WIDTH-1:0]          out_corr
);

    pp_state_e                   state_q, state_d;
    logic [WIDTH-1:0][WIDTH-1:0] head_pp_q, head_pp_d, skid_pp_q, skid_pp_d;
    logic [2*WIDTH-1:0]          head_corr_q, head_corr_d, skid_corr_q, skid_corr_d;
    logic [WIDTH-1:0][WIDTH-1:0] new_pp_s;
    logic [2*WIDTH-1:0]          new_corr_s;
    logic                        accept_s;
    logic                        drain_s;

    pp_matrix #(
        .WIDTH    (WIDTH),
        .SIGNED_EN(SIGNED_EN)
    ) u_matrix (
        .a_i     (in_a),
        .b_i     (in_b),
        .signed_i(in_signed),
        .pp_o    (new_pp_s),
        .corr_o  (new_corr_s)
    );

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept_s  = in_valid & in_ready;
    assign drain_s   = out_valid & out_ready;
    assign out_pp    = head_pp_q;
    assign out_corr  = head_corr_q;

    // Buffer occupancy and head/skid data movement.
    always_comb begin
        state_d     = state_q;
        head_pp_d   = head_pp_q;
        head_corr_d = head_corr_q;
        skid_pp_d   = skid_pp_q;
        skid_corr_d = skid_corr_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    head_pp_d   = new_pp_s;
                    head_corr_d = new_corr_s;
                    state_d     = ST_ONE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    head_pp_d   = new_pp_s;
                    head_corr_d = new_corr_s;
                end else if (accept_s) begin
                    skid_pp_d   = new_pp_s;
                    skid_corr_d = new_corr_s;
                    state_d     = ST_FULL;
                end else if (drain_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    head_pp_d   = skid_pp_q;
                    head_corr_d = skid_corr_q;
                    state_d     = ST_ONE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and entry registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_pp_q   <= '0;
            head_corr_q <= '0;
            skid_pp_q   <= '0;
            skid_corr_q <= '0;
        end else begin
            state_q     <= state_d;
            head_pp_q   <= head_pp_d;
            head_corr_q <= head_corr_d;
            skid_pp_q   <= skid_pp_d;
            skid_corr_q <= skid_corr_d;
        end
    end

endmodule

// File: tb/tb_pp_gen_pipe.sv
// Self-checking bench: directed 8-bit signed cases plus randomized streams on 8- and 16-bit instances.
module tb_pp_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic            a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
    logic [7:0]      a_in_a, a_in_b;
    logic [7:0][7:0] a_out_pp;
    logic [15:0]     a_out_corr;

    logic              b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
    logic [15:0]       b_in_a, b_in_b;
    logic [15:0][15:0] b_out_pp;
    logic [31:0]       b_out_corr;

    int n_tests = 0;
    int n_fail  = 0;

    pp_gen_pipe #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_signed(a_in_signed),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pp(a_out_pp), .out_corr(a_out_corr)
    );

    pp_gen_pipe #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_signed(b_in_signed),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pp(b_out_pp), .out_corr(b_out_corr)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wsum8(input logic [7:0][7:0] pp, input logic [15:0] corr);
        logic [15:0] s;
        s = corr;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (pp[i][j]) s = s + (16'd1 << (i + j));
        return s;
    endfunction

    function automatic logic [31:0] wsum16(input logic [15:0][15:0] pp, input logic [31:0] corr);
        logic [31:0] s;
        s = corr;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                if (pp[i][j]) s = s + (32'd1 << (i + j));
        return s;
    endfunction

    function automatic logic [15:0] prod8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [15:0] ae, be;
        ae = s ? {{8{a[7]}}, a} : {8'd0, a};
        be = s ? {{8{b[7]}}, b} : {8'd0, b};
        return ae * be;
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic v);
        a_in_a      = a;
        a_in_b      = b;
        a_in_signed = s;
        a_in_valid  = v;
    endtask

    logic [7:0]      ta [3];
    logic [7:0]      tb [3];
    logic            ts [3];
    logic [7:0][7:0] saved8;
    logic [31:0]     q8 [$];
    logic [31:0]     q16 [$];

    initial begin
        rst = 1'b1;
        drive8(8'd0, 8'd0, 1'b0, 1'b0);
        a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_a = 16'd0; b_in_b = 16'd0; b_in_signed = 1'b0; b_out_ready = 1'b0;
        #12;
        check_val("rst_valid8", a_out_valid, 1'b0);
        check_val("rst_ready8", a_in_ready, 1'b1);
        check_val("rst_pp8", a_out_pp, 64'd0);
        check_val("rst_corr8", a_out_corr, 16'd0);
        check_val("rst_valid16", b_out_valid, 1'b0);
        check_val("rst_pp16", |b_out_pp, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned all-ones
        @(negedge clk);
        a_out_ready = 1'b1;
        drive8(8'hFF, 8'hFF, 1'b0, 1'b1);
        check_val("ff_ready", a_in_ready, 1'b1);
        @(negedge clk);
        check_val("ff_valid", a_out_valid, 1'b1);
        check_val("ff_pp", a_out_pp, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("ff_corr", a_out_corr, 16'd0);
        check_val("ff_sum", wsum8(a_out_pp, a_out_corr), 16'hFE01);

        // Signed -1 * 2
        drive8(8'hFF, 8'h02, 1'b1, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        check_val("sg_valid", a_out_valid, 1'b1);
        check_val("sg_pp71", a_out_pp[7][1], 1'b0);
        for (int i = 0; i < 7; i++) check_val("sg_ppi7", a_out_pp[i][7], 1'b1);
        check_val("sg_corr", a_out_corr, 16'h8100);
        check_val("sg_sum", wsum8(a_out_pp, a_out_corr), 16'hFFFE);
        @(negedge clk);
        check_val("sg_drained", a_out_valid, 1'b0);

        // Back-to-back
        for (int k = 0; k < 3; k++) begin
            ta[k] = 8'($urandom); tb[k] = 8'($urandom); ts[k] = 1'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check_val("b2b_valid", a_out_valid, 1'b1);
                check_val("b2b_sum", wsum8(a_out_pp, a_out_corr), prod8(ta[k-1], tb[k-1], ts[k-1]));
            end
            if (k < 3) begin
                drive8(ta[k], tb[k], ts[k], 1'b1);
                check_val("b2b_ready", a_in_ready, 1'b1);
            end else begin
                a_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_val("b2b_empty", a_out_valid, 1'b0);

        // Stall with full skid buffer
        for (int k = 0; k < 3; k++) begin
            ta[k] = 8'($urandom); tb[k] = 8'($urandom); ts[k] = 1'($urandom);
        end
        a_out_ready = 1'b0;
        drive8(ta[0], tb[0], ts[0], 1'b1);
        check_val("st_ready0", a_in_ready, 1'b1);
        @(negedge clk);
        check_val("st_ready1", a_in_ready, 1'b1);
        check_val("st_head0", wsum8(a_out_pp, a_out_corr), prod8(ta[0], tb[0], ts[0]));
        drive8(ta[1], tb[1], ts[1], 1'b1);
        @(negedge clk);
        check_val("st_full", a_in_ready, 1'b0);
        check_val("st_head0b", wsum8(a_out_pp, a_out_corr), prod8(ta[0], tb[0], ts[0]));
        saved8 = a_out_pp;
        drive8(ta[2], tb[2], ts[2], 1'b1);
        @(negedge clk);
        check_val("st_stable", a_out_pp, saved8);
        check_val("st_full2", a_in_ready, 1'b0);
        a_out_ready = 1'b1;
        @(negedge clk);
        check_val("st_out1", wsum8(a_out_pp, a_out_corr), prod8(ta[1], tb[1], ts[1]));
        check_val("st_ready_again", a_in_ready, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        check_val("st_out2", wsum8(a_out_pp, a_out_corr), prod8(ta[2], tb[2], ts[2]));
        @(negedge clk);
        check_val("st_empty", a_out_valid, 1'b0);

        // Reset with a full buffer
        a_out_ready = 1'b0;
        drive8(8'h5A, 8'hC3, 1'b1, 1'b1);
        @(negedge clk);
        drive8(8'h7E, 8'h81, 1'b0, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        check_val("rs_full", a_in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_val("rs_valid", a_out_valid, 1'b0);
        check_val("rs_ready", a_in_ready, 1'b1);
        check_val("rs_pp", a_out_pp, 64'd0);
        check_val("rs_corr", a_out_corr, 16'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rs_still_empty", a_out_valid, 1'b0);
        a_out_ready = 1'b1;
        drive8(8'd3, 8'd5, 1'b0, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        check_val("rs_valid15", a_out_valid, 1'b1);
        check_val("rs_sum15", wsum8(a_out_pp, a_out_corr), 16'd15);

        // Random 8-bit mixed signed/unsigned stream at full rate
        q8.delete();
        for (int k = 0; k <= 200; k++) begin
            @(negedge clk);
            if (k < 200) drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            else a_in_valid = 1'b0;
            #1;
            if (k < 200) check_val("r8_ready", a_in_ready, 1'b1);
            if (a_out_valid) begin
                check_val("r8_nonempty", q8.size() != 0, 1'b1);
                if (q8.size() != 0) begin
                    logic [31:0] e;
                    e = q8.pop_front();
                    check_val("r8_sum", wsum8(a_out_pp, a_out_corr), e[15:0]);
                    check_val("r8_corr", a_out_corr, e[31:16]);
                end
            end
            if (a_in_valid && a_in_ready)
                q8.push_back({(a_in_signed ? 16'h8100 : 16'h0000), prod8(a_in_a, a_in_b, a_in_signed)});
        end
        check_val("r8_all_out", q8.size(), 0);

        // Random 16-bit unsigned-only instance with random backpressure
        begin
            int accepted = 0;
            int cyc = 0;
            logic hold = 1'b0;
            logic prev_stall = 1'b0;
            logic [15:0][15:0] saved16 = '0;
            logic [31:0] saved_c16 = 32'd0;
            q16.delete();
            while ((accepted < 1000 || q16.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                if (!hold) begin
                    b_in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
                    b_in_a      = 16'($urandom);
                    b_in_b      = 16'($urandom);
                    b_in_signed = 1'($urandom);
                end
                b_out_ready = ($urandom_range(0, 2) != 0);
                #1;
                if (prev_stall) begin
                    check_val("r16_stable", (b_out_pp == saved16) && (b_out_corr == saved_c16), 1'b1);
                end
                prev_stall = b_out_valid && !b_out_ready;
                saved16    = b_out_pp;
                saved_c16  = b_out_corr;
                if (b_out_valid && b_out_ready) begin
                    check_val("r16_nonempty", q16.size() != 0, 1'b1);
                    if (q16.size() != 0) begin
                        check_val("r16_sum", wsum16(b_out_pp, b_out_corr), q16.pop_front());
                        check_val("r16_corr", b_out_corr, 32'd0);
                    end
                end
                hold = b_in_valid && !b_in_ready;
                if (b_in_valid && b_in_ready) begin
                    q16.push_back(32'(b_in_a) * 32'(b_in_b));
                    accepted++;
                end
            end
            b_in_valid = 1'b0;
            check_val("r16_finished", cyc < 20000, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
